// File: rtl/radio_serializer.sv
// Packs N_CHAN I/Q samples into MSB-first serial frames (optional even parity), SYNC on bit 0; one-edge capture-to-bit-0 latency.
// No backpressure: a single hold register buffers the next word, and a strobe that finds it still occupied overwrites it and flags OVERRUN.
module radio_serializer #(
  parameter int N_CHAN = 2,
  parameter int PARITY = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  TEST_MODE,
  input  logic                  SAMPLE_EN,
  input  logic [4*N_CHAN-1:0]   RX_DATA,
  input  logic                  CLR_OVR,
  output logic                  DATA_OUT,
  output logic                  SYNC,
  output logic                  OVERRUN,
  output logic [CNT_W-1:0]      FRAME_CNT
);
  localparam int W    = 4 * N_CHAN;
  localparam int FLEN = W + PARITY;
  localparam int IW   = $clog2(FLEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FLEN - 1);
  localparam logic [IW-1:0] PAR_IDX  = IW'(W - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  hold;
  logic [W-1:0]  pat;
  logic [W-1:0]  sr;
  logic          hold_valid;
  logic          par;
  logic [IW-1:0] bit_idx;
  logic          capture;
  logic          last_bit;
  logic          load;

  assign capture  = SAMPLE_EN & ENABLE;
  // bit_idx is the index of the bit currently on DATA_OUT
  assign last_bit = (state == SHIFT) && (bit_idx == LAST_IDX);
  assign load     = hold_valid && ((state == IDLE) || last_bit);

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      pat        <= '0;
      sr         <= '0;
      par        <= 1'b0;
      bit_idx    <= '0;
      DATA_OUT   <= 1'b0;
      SYNC       <= 1'b0;
      OVERRUN    <= 1'b0;
      FRAME_CNT  <= '0;
    end else begin
      if (capture) begin
        hold <= TEST_MODE ? pat : RX_DATA;
        if (TEST_MODE) begin
          pat <= pat + W'(1);
        end
      end

      // A capture on the load edge refills hold without counting as an overrun.
      hold_valid <= capture | (hold_valid & ~load);
      if (capture && hold_valid && !load) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVR) begin
        OVERRUN <= 1'b0;
      end

      if (load) begin
        state     <= SHIFT;
        sr        <= {hold[W-2:0], 1'b0};
        par       <= ^hold;
        bit_idx   <= '0;
        DATA_OUT  <= hold[W-1];
        SYNC      <= 1'b1;
        FRAME_CNT <= FRAME_CNT + CNT_W'(1);
      end else if (state == SHIFT && !last_bit) begin
        bit_idx  <= bit_idx + IW'(1);
        DATA_OUT <= (bit_idx == PAR_IDX) ? par : sr[W-1];
        sr       <= {sr[W-2:0], 1'b0};
        SYNC     <= 1'b0;
      end else begin
        state    <= IDLE;
        DATA_OUT <= 1'b0;
        SYNC     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_radio_serializer.sv
// Bench for radio_serializer: vector table, hand-written multi-cycle sequences and
// randomized strobes scored against a frame-level reference model.
module tb_radio_serializer;
  localparam int W    = 8;
  localparam int FLEN = 9;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b1;
  logic        TEST_MODE = 1'b0;
  logic        SAMPLE_EN = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        CLR_OVR = 1'b0;
  logic        DATA_OUT;
  logic        SYNC;
  logic        OVERRUN;
  logic [15:0] FRAME_CNT;

  radio_serializer dut (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .TEST_MODE (TEST_MODE),
    .SAMPLE_EN (SAMPLE_EN),
    .RX_DATA   (RX_DATA),
    .CLR_OVR   (CLR_OVR),
    .DATA_OUT  (DATA_OUT),
    .SYNC      (SYNC),
    .OVERRUN   (OVERRUN),
    .FRAME_CNT (FRAME_CNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int nchk = 0;
  int nerr = 0;
  int fc_exp = 0;
  bit mon_on = 1'b0;
  logic [7:0] exp_q[$];

  // per-cycle schedule and captured outputs for the hand-written sequences
  logic       s_on [0:63];
  logic [7:0] s_dat[0:63];
  logic       s_clr[0:63];
  logic       s_rst[0:63];
  logic       s_dis[0:63];
  logic       g_d  [0:63];
  logic       g_s  [0:63];
  logic       g_o  [0:63];

  typedef struct {
    logic [7:0] dat;
    logic [8:0] ser;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic clear_sched();
    for (int c = 0; c < 64; c++) begin
      s_on[c] = 1'b0; s_dat[c] = 8'h00; s_clr[c] = 1'b0; s_rst[c] = 1'b0; s_dis[c] = 1'b0;
    end
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      SAMPLE_EN = s_on[c];
      RX_DATA   = s_dat[c];
      CLR_OVR   = s_clr[c];
      RST       = s_rst[c];
      ENABLE    = !s_dis[c];
      step();
      g_d[c] = DATA_OUT;
      g_s[c] = SYNC;
      g_o[c] = OVERRUN;
    end
    SAMPLE_EN = 1'b0; CLR_OVR = 1'b0; RST = 1'b0; ENABLE = 1'b1;
    clear_sched();
  endtask

  task automatic get_bits(input int from, input int len, output logic [31:0] d, output logic [31:0] s);
    d = '0;
    s = '0;
    for (int i = 0; i < len; i++) begin
      d = {d[30:0], g_d[from + i]};
      s = {s[30:0], g_s[from + i]};
    end
  endtask

  // Frame monitor: rebuilds every frame from the serial stream and scores it
  // against the expected word queue (data MSB first, then the XOR of the data).
  int         bitpos = -1;
  logic [8:0] fr;
  logic [7:0] fe;
  always @(negedge SYS_CLK) begin
    if (mon_on) begin
      if (SYNC === 1'b1) begin
        if (bitpos != -1) chk("sync_mid_frame", 32'(bitpos), 32'(FLEN));
        fr = {8'h00, DATA_OUT};
        bitpos = 1;
      end else if (bitpos != -1) begin
        fr = {fr[7:0], DATA_OUT};
        bitpos++;
      end else begin
        chk("idle_data", 32'(DATA_OUT), 32'd0);
      end
      if (bitpos == FLEN) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(fr), 32'h1ff);
        end else begin
          fe = exp_q.pop_front();
          chk("frame_word", 32'(fr), 32'({fe, ^fe}));
        end
        bitpos = -1;
      end
      if (RST === 1'b1) bitpos = -1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] d, s;
  logic [7:0]  pat_m;
  logic [7:0]  rd;
  bit          ren, rtm;

  initial begin
    tbl[0] = '{8'hA5, 9'b101001010};
    tbl[1] = '{8'h33, 9'b001100110};
    tbl[2] = '{8'hC3, 9'b110000110};
    tbl[3] = '{8'hFF, 9'b111111110};
    tbl[4] = '{8'h00, 9'b000000000};
    tbl[5] = '{8'h7E, 9'b011111100};
    tbl[6] = '{8'h80, 9'b100000001};
    clear_sched();

    // Reset held for two edges while strobing in test mode: nothing captured.
    RST = 1'b1; SAMPLE_EN = 1'b1; ENABLE = 1'b1; TEST_MODE = 1'b1; RX_DATA = 8'hAA;
    step(); step();
    chk("rst_data", 32'(DATA_OUT), 32'd0);
    chk("rst_sync", 32'(SYNC), 32'd0);
    chk("rst_ovr", 32'(OVERRUN), 32'd0);
    chk("rst_cnt", 32'(FRAME_CNT), 32'd0);
    RST = 1'b0; SAMPLE_EN = 1'b0; TEST_MODE = 1'b0;
    step(); step();
    chk("post_rst_data", 32'(DATA_OUT), 32'd0);
    chk("post_rst_sync", 32'(SYNC), 32'd0);
    mon_on = 1'b1;

    // Single words from the vector table.
    for (int i = 0; i < 7; i++) begin
      s_on[0] = 1'b1; s_dat[0] = tbl[i].dat;
      exp_q.push_back(tbl[i].dat);
      run(11);
      get_bits(1, 9, d, s);
      chk("tbl_serial", d, 32'(tbl[i].ser));
      chk("tbl_sync", s, 32'h100);
      chk("tbl_idle_data", 32'(g_d[10]), 32'd0);
      chk("tbl_idle_sync", 32'(g_s[10]), 32'd0);
      fc_exp++;
      chk("tbl_cnt", 32'(FRAME_CNT), 32'(fc_exp));
    end

    // Back-to-back frames, strobes nine edges apart.
    s_on[0] = 1'b1; s_dat[0] = 8'h01;
    s_on[9] = 1'b1; s_dat[9] = 8'h80;
    exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    run(20);
    get_bits(1, 18, d, s);
    chk("b2b_serial", d, 32'(18'b000000011_100000001));
    chk("b2b_sync", s, 32'(18'b100000000_100000000));
    chk("b2b_idle", 32'({g_d[19], g_s[19]}), 32'd0);
    chk("b2b_ovr", 32'(g_o[19]), 32'd0);
    fc_exp += 2;

    // Three strobes on consecutive edges: middle word is overwritten.
    s_on[0] = 1'b1; s_dat[0] = 8'h11;
    s_on[1] = 1'b1; s_dat[1] = 8'h22;
    s_on[2] = 1'b1; s_dat[2] = 8'h33;
    exp_q.push_back(8'h11); exp_q.push_back(8'h33);
    run(20);
    chk("ovr_simul_load", 32'(g_o[1]), 32'd0);
    chk("ovr_set", 32'(g_o[2]), 32'd1);
    get_bits(1, 18, d, s);
    chk("ovr_serial", d, 32'(18'b000100010_001100110));
    chk("ovr_sync", s, 32'(18'b100000000_100000000));
    chk("ovr_sticky", 32'(g_o[19]), 32'd1);
    s_clr[0] = 1'b1;
    run(2);
    chk("ovr_clear", 32'(g_o[0]), 32'd0);

    // Overrun on the same edge as CLR_OVR: set wins.
    s_on[0] = 1'b1; s_dat[0] = 8'h44;
    s_on[1] = 1'b1; s_dat[1] = 8'h55;
    s_on[2] = 1'b1; s_dat[2] = 8'h66; s_clr[2] = 1'b1;
    exp_q.push_back(8'h44); exp_q.push_back(8'h66);
    run(20);
    chk("ovr_set_wins", 32'(g_o[2]), 32'd1);
    fc_exp += 4;
    chk("ovr_cnt", 32'(FRAME_CNT), 32'(fc_exp));
    s_clr[0] = 1'b1;
    run(1);

    // ENABLE low blocks new captures but the frame and held word still go out.
    s_on[0] = 1'b1; s_dat[0] = 8'h96;
    s_on[3] = 1'b1; s_dat[3] = 8'h3C;
    s_on[5] = 1'b1; s_dat[5] = 8'hFF;
    for (int c = 4; c < 25; c++) s_dis[c] = 1'b1;
    exp_q.push_back(8'h96); exp_q.push_back(8'h3C);
    run(25);
    get_bits(1, 18, d, s);
    chk("en_serial", d, 32'(18'b100101100_001111000));
    chk("en_idle", 32'({g_d[19], g_s[19]}), 32'd0);
    chk("en_no_ovr", 32'(g_o[24]), 32'd0);
    fc_exp += 2;
    chk("en_cnt", 32'(FRAME_CNT), 32'(fc_exp));

    // Test mode: counter words 00, 01, 02 regardless of RX_DATA.
    TEST_MODE = 1'b1;
    s_on[0] = 1'b1;  s_dat[0] = 8'hFF;
    s_on[12] = 1'b1; s_dat[12] = 8'hFF;
    s_on[24] = 1'b1; s_dat[24] = 8'hFF;
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    run(36);
    TEST_MODE = 1'b0;
    get_bits(1, 9, d, s);
    chk("tm_frame0", d, 32'(9'b000000000));
    get_bits(13, 9, d, s);
    chk("tm_frame1", d, 32'(9'b000000011));
    get_bits(25, 9, d, s);
    chk("tm_frame2", d, 32'(9'b000000101));
    fc_exp += 3;

    // Reset after four bits of a frame, with a strobe on the reset edge.
    s_on[0] = 1'b1; s_dat[0] = 8'h5A;
    s_rst[5] = 1'b1; s_on[5] = 1'b1; s_dat[5] = 8'hFF;
    run(6);
    chk("midrst_data", 32'(g_d[5]), 32'd0);
    chk("midrst_sync", 32'(g_s[5]), 32'd0);
    chk("midrst_cnt", 32'(FRAME_CNT), 32'd0);
    fc_exp = 0;
    s_on[0] = 1'b1; s_dat[0] = 8'hC3;
    exp_q.push_back(8'hC3);
    run(12);
    get_bits(1, 9, d, s);
    chk("midrst_serial", d, 32'(9'b110000110));
    chk("midrst_sync1", s, 32'h100);
    chk("midrst_tail", 32'({g_d[10], g_s[10], g_d[11], g_s[11]}), 32'd0);
    fc_exp = 1;
    chk("midrst_cnt1", 32'(FRAME_CNT), 32'd1);

    // Randomized strobes; model tracks captured words and the test counter.
    pat_m = 8'h00;
    for (int i = 0; i < 400; i++) begin
      rd  = 8'($urandom);
      ren = ($urandom_range(0, 7) != 0);
      rtm = ($urandom_range(0, 3) != 0);
      RX_DATA = rd; ENABLE = ren; TEST_MODE = rtm; SAMPLE_EN = 1'b1;
      if (ren) begin
        exp_q.push_back(rtm ? pat_m : rd);
        if (rtm) pat_m = pat_m + 8'd1;
        fc_exp++;
      end
      step();
      SAMPLE_EN = 1'b0; ENABLE = 1'b1; TEST_MODE = 1'b0; RX_DATA = 8'($urandom);
      repeat ($urandom_range(FLEN - 1, FLEN + 4)) step();
    end
    repeat (15) step();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_ovr", 32'(OVERRUN), 32'd0);
    chk("rand_cnt", 32'(FRAME_CNT), 32'(fc_exp));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
